// File: rtl/nonce_decode.sv
// nonce_decode: rebuilds a 32-bit nonce from a short byte stream.
// The first beat of a frame names the first byte that carries real data.
// Bytes before it are 0xff. The following beats fill the remaining bytes in order.
// A first beat with not_found_in set gives an all-0xff nonce straight away.
// Byte 0 is nonce_out[0:7], the most significant byte.
module nonce_decode (
  input  logic        clk_a,
  input  logic        reset_L,
  input  logic        inicio,
  input  logic        valid_in,
  input  logic [0:7]  data_in,
  input  logic [0:4]  idx_in,
  input  logic        not_found_in,
  output logic [0:31] nonce_out,
  output logic        nonce_valid,
  output logic        busy,
  output logic        error_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [3:0]  idle_cnt;
  logic [1:0]  first_idx;
  logic [0:31] first_nonce;

  // A legal first index fits in two bits. Wider values are rejected separately.
  assign first_idx = idx_in[3:4];

  // Nonce produced by a legal first beat: 0xff below k, data at k, zeros above k.
  always_comb begin
    first_nonce = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(first_idx)) begin
        first_nonce[8*i +: 8] = 8'hff;
      end else if (i == int'(first_idx)) begin
        first_nonce[8*i +: 8] = data_in;
      end else begin
        first_nonce[8*i +: 8] = 8'h00;
      end
    end
  end

  // Frame FSM. Every output is registered.
  // A pulse is raised on the same edge that enters DONE or ERR.
  always_ff @(posedge clk_a or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      nonce_out   <= '0;
      nonce_valid <= 1'b0;
      busy        <= 1'b0;
      error_out   <= 1'b0;
      ptr         <= 2'd0;
      idle_cnt    <= 4'd0;
    end else begin
      nonce_valid <= 1'b0;
      error_out   <= 1'b0;
      if (!inicio) begin
        state    <= IDLE;
        busy     <= 1'b0;
        ptr      <= 2'd0;
        idle_cnt <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (valid_in) begin
              idle_cnt <= 4'd0;
              if (not_found_in) begin
                nonce_out   <= '1;
                nonce_valid <= 1'b1;
                state       <= DONE;
              end else if (idx_in > 5'd3) begin
                error_out <= 1'b1;
                state     <= ERR;
              end else begin
                nonce_out <= first_nonce;
                if (first_idx == 2'd3) begin
                  nonce_valid <= 1'b1;
                  state       <= DONE;
                end else begin
                  ptr   <= first_idx + 2'd1;
                  busy  <= 1'b1;
                  state <= FILL;
                end
              end
            end
          end
          FILL: begin
            if (valid_in) begin
              nonce_out[{ptr, 3'b000} +: 8] <= data_in;
              idle_cnt <= 4'd0;
              if (ptr == 2'd3) begin
                ptr         <= 2'd0;
                busy        <= 1'b0;
                nonce_valid <= 1'b1;
                state       <= DONE;
              end else begin
                ptr <= ptr + 2'd1;
              end
            end else if (idle_cnt == 4'd14) begin
              idle_cnt  <= 4'd0;
              ptr       <= 2'd0;
              busy      <= 1'b0;
              error_out <= 1'b1;
              state     <= ERR;
            end else begin
              idle_cnt <= idle_cnt + 4'd1;
            end
          end
          DONE: state <= IDLE;
          ERR:  state <= IDLE;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/nonce_decode.md
NONCE_DECODE -- requirements
Module: nonce_decode

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL have port clk_a, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port inicio, input, 1 bit: block enable; low aborts and idles the block.
REQ-005 SHALL have port valid_in, input, 1 bit: a beat is present on data_in, idx_in and not_found_in.
REQ-006 SHALL have port data_in[0:7], input, 8 bits: byte value of the current beat.
REQ-007 SHALL have port idx_in[0:4], input, 5 bits: byte index, used only on the first beat of a frame.
REQ-008 SHALL have port not_found_in, input, 1 bit: used only on the first beat; means the nonce is all 0xff.
REQ-009 SHALL have port nonce_out[0:31], output, 32 bits: reconstructed nonce; bits [0:7] are byte 0.
REQ-010 SHALL have port nonce_valid, output, 1 bit: one-cycle pulse, nonce_out is complete.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port error_out, output, 1 bit: one-cycle pulse, frame rejected.

Function
REQ-013 SHALL implement states IDLE, FILL, DONE and ERR; every output is registered.
REQ-014 In IDLE with inicio=1 and valid_in=1 (first beat), SHALL accept the beat whatever its contents.
REQ-015 On a first beat with not_found_in=1, SHALL load nonce_out=32'hffffffff and go to DONE; data_in and idx_in are ignored.
REQ-016 On a first beat with not_found_in=0 and idx_in=k (k<=3), SHALL do all of the following at the same edge:
- set bytes 0..k-1 of nonce_out to 8'hff;
- write data_in into byte k;
- set bytes k+1..3 to 8'h00.
REQ-017 After REQ-016, if k=3 SHALL go to DONE; otherwise SHALL load the byte pointer with k+1 and go to FILL.
REQ-018 On a first beat with not_found_in=0 and idx_in>3, SHALL go to ERR and SHALL leave nonce_out unchanged.
REQ-019 In FILL, each cycle with valid_in=1 SHALL write data_in into the byte at the pointer and increment the pointer.
REQ-020 In FILL, when the byte written is byte 3, SHALL go to DONE.
REQ-021 In FILL, idx_in and not_found_in SHALL be ignored.
REQ-022 In FILL, a 4-bit idle counter SHALL:
- clear on every valid_in=1 cycle;
- increment on every valid_in=0 cycle;
- on reaching 15, force ERR.
REQ-023 DONE SHALL last one cycle with nonce_valid=1, then go to IDLE.
REQ-024 Timing: if the last byte is captured at edge N, nonce_valid SHALL be high from edge N until edge N+1.
REQ-025 A valid_in=1 beat during DONE SHALL be dropped.
REQ-026 ERR SHALL last one cycle with error_out=1, then go to IDLE.
REQ-027 busy SHALL equal 1 exactly while the state is FILL.
REQ-028 nonce_out SHALL hold its value in IDLE, DONE and ERR until the next accepted first beat.
REQ-029 inicio=0 in any state SHALL force IDLE at the next edge with these effects:
- no nonce_valid and no error_out pulse;
- idle counter and byte pointer cleared;
- nonce_out kept.
REQ-030 inicio=0 SHALL take priority over valid_in arriving in the same cycle.
REQ-031 The byte pointer is 2 bits and SHALL never wrap past byte 3 within a frame.

Reset
REQ-032 While reset_L=0, regardless of clk_a, SHALL force:
- state=IDLE;
- nonce_out=32'h00000000;
- nonce_valid=0, busy=0, error_out=0;
- idle counter=0 and byte pointer=0.
REQ-033 Reset deassertion SHALL take effect at the first clk_a edge after reset_L rises.
REQ-034 Reset asserted mid-frame SHALL discard the partial nonce, with no pulse on any output.

Verification
REQ-035 Bench SHALL drive: first beat idx=0, data=8'h12, then beats 8'h34, 8'h56, 8'h78. Required: nonce_out=32'h12345678, one nonce_valid pulse, busy high for 3 cycles.
REQ-036 Bench SHALL drive: first beat idx=2, data=8'hab, then beat 8'hcd. Required: nonce_out=32'hffffabcd with nonce_valid.
REQ-037 Bench SHALL drive: not_found_in=1 with data=8'hfe. Required: nonce_out=32'hffffffff and nonce_valid the cycle after the beat.
REQ-038 Bench SHALL drive: first beat idx=5. Required: error_out pulse, nonce_out unchanged, state back to IDLE.
REQ-039 Bench SHALL drive: idx=0 frame, then 15 idle cycles in FILL. Required: error_out pulse, no nonce_valid.
REQ-040 Bench SHALL drive: inicio low mid-FILL, and reset_L low mid-FILL. Required: IDLE next edge, no pulses; reset_L low gives nonce_out=0.
